// File: rtl/exu_div_iter_pkg.sv
// Shared types and widths for the EXU iterative divider.
package exu_div_iter_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_CALC,
        DIV_FIX
    } div_state_t;

    typedef struct packed {
        logic             rem;
        logic             unsign;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [RD_W-1:0]  rd_addr;
        logic [TAG_W-1:0] instr_tag;
    } div_req_t;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? XLEN'(~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/exu_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: trivial cases skip CALC and complete from PREP.
module exu_div_iter
    import exu_div_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_start,
    input  logic             div_rem,
    input  logic             div_unsign,
    input  logic [XLEN-1:0]  div_rs1_data,
    input  logic [XLEN-1:0]  div_rs2_data,
    input  logic [RD_W-1:0]  div_rd_addr,
    input  logic [TAG_W-1:0] div_instr_tag,
    input  logic             pipe_flush,
    output logic             exu_div_busy,
    output logic             div_wb_valid,
    output logic [XLEN-1:0]  div_wb_data,
    output logic [RD_W-1:0]  div_wb_rd_addr,
    output logic [TAG_W-1:0] div_wb_tag
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state, state_nxt;
    div_req_t         req;
    logic [XLEN-1:0]  abs_b, quo, rem;
    logic [CNT_W-1:0] cnt;
    logic             wb_valid_q;

    logic             accept, a_neg_c, b_neg_c, div0_c, ovf_c, early_c, ge_c;
    logic [XLEN-1:0]  abs_a_c, abs_b_c, quo_nxt_c, rem_nxt_c, fix_quo_c, fix_rem_c;
    logic [XLEN:0]    shifted_c;

    // Final result selection with RISC-V special cases forced.
    function automatic logic [XLEN-1:0] fix_result(
        input logic            sel_rem,
        input logic [XLEN-1:0] dividend,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            q_neg,
        input logic            r_neg,
        input logic            div0,
        input logic            ovf
    );
        if (div0)
            return sel_rem ? dividend : '1;
        if (ovf)
            return sel_rem ? '0 : INT_MIN;
        return sel_rem ? neg_if(r, r_neg) : neg_if(q, q_neg);
    endfunction

    assign accept  = (state == DIV_IDLE) & div_start & ~pipe_flush;
    // Signs and special cases derive from the request, which is stable for the whole op.
    assign a_neg_c = ~req.unsign & req.rs1_data[XLEN-1];
    assign b_neg_c = ~req.unsign & req.rs2_data[XLEN-1];
    assign abs_a_c = neg_if(req.rs1_data, a_neg_c);
    assign abs_b_c = neg_if(req.rs2_data, b_neg_c);
    assign div0_c  = (req.rs2_data == '0);
    assign ovf_c   = ~req.unsign & (req.rs1_data == INT_MIN) & (req.rs2_data == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early_c = div0_c | ovf_c | (abs_a_c < abs_b_c);
`else
    assign early_c = 1'b0;
`endif

    // One restoring step.
    assign shifted_c = {rem, quo[XLEN-1]};
    assign ge_c      = (shifted_c >= {1'b0, abs_b});
    assign rem_nxt_c = ge_c ? XLEN'(shifted_c - {1'b0, abs_b}) : shifted_c[XLEN-1:0];
    assign quo_nxt_c = {quo[XLEN-2:0], ge_c};

    // Early-out from PREP means |a| < |b| (or a forced case): quotient 0, remainder |a|.
    assign fix_quo_c = (state == DIV_CALC) ? quo_nxt_c : '0;
    assign fix_rem_c = (state == DIV_CALC) ? rem_nxt_c : abs_a_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= DIV_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pipe_flush) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (div_start) state_nxt = DIV_PREP;
                DIV_PREP: state_nxt = early_c ? DIV_FIX : DIV_CALC;
                DIV_CALC: if (cnt == CNT_W'(XLEN-1)) state_nxt = DIV_FIX;
                DIV_FIX:  state_nxt = DIV_IDLE;
                default:  state_nxt = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req            <= '0;
            abs_b          <= '0;
            quo            <= '0;
            rem            <= '0;
            cnt            <= '0;
            wb_valid_q     <= 1'b0;
            div_wb_data    <= '0;
            div_wb_rd_addr <= '0;
            div_wb_tag     <= '0;
        end else begin
            wb_valid_q <= (state_nxt == DIV_FIX);
            if (accept)
                req <= {div_rem, div_unsign, div_rs1_data, div_rs2_data, div_rd_addr, div_instr_tag};
            case (state)
                DIV_PREP: begin
                    quo   <= abs_a_c;
                    rem   <= '0;
                    abs_b <= abs_b_c;
                    cnt   <= '0;
                end
                DIV_CALC: begin
                    quo <= quo_nxt_c;
                    rem <= rem_nxt_c;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (state_nxt == DIV_FIX) begin
                div_wb_data    <= fix_result(req.rem, req.rs1_data, fix_quo_c, fix_rem_c,
                                             a_neg_c ^ b_neg_c, a_neg_c, div0_c, ovf_c);
                div_wb_rd_addr <= req.rd_addr;
                div_wb_tag     <= req.instr_tag;
            end
        end
    end

    assign exu_div_busy = (state != DIV_IDLE);
    // A flush in the FIX cycle must kill the strobe in that same cycle.
    assign div_wb_valid = wb_valid_q & ~pipe_flush;

endmodule

// File: tb/tb_exu_div_iter.sv
// Scoreboard bench for exu_div_iter: directed divides, special cases, flush and hold-start.
module tb_exu_div_iter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 8;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             div_start = 1'b0;
    logic             div_rem = 1'b0;
    logic             div_unsign = 1'b0;
    logic [XLEN-1:0]  div_rs1_data = '0;
    logic [XLEN-1:0]  div_rs2_data = '0;
    logic [4:0]       div_rd_addr = '0;
    logic [TAG_W-1:0] div_instr_tag = '0;
    logic             pipe_flush = 1'b0;
    logic             exu_div_busy;
    logic             div_wb_valid;
    logic [XLEN-1:0]  div_wb_data;
    logic [4:0]       div_wb_rd_addr;
    logic [TAG_W-1:0] div_wb_tag;

    exu_div_iter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .div_start      (div_start),
        .div_rem        (div_rem),
        .div_unsign     (div_unsign),
        .div_rs1_data   (div_rs1_data),
        .div_rs2_data   (div_rs2_data),
        .div_rd_addr    (div_rd_addr),
        .div_instr_tag  (div_instr_tag),
        .pipe_flush     (pipe_flush),
        .exu_div_busy   (exu_div_busy),
        .div_wb_valid   (div_wb_valid),
        .div_wb_data    (div_wb_data),
        .div_wb_rd_addr (div_wb_rd_addr),
        .div_wb_tag     (div_wb_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic [7:0]      tag;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops the scoreboard on every writeback strobe.
    always @(negedge clk) begin
        if (rst_n && div_wb_valid) begin
            if (sb.size() == 0) begin
                chk("stray_wb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_data", div_wb_data, e.data);
                chk("wb_rd", 32'(div_wb_rd_addr), 32'(e.rd));
                chk("wb_tag", 32'(div_wb_tag), 32'(e.tag));
                chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic rm, input logic uns, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [7:0] tag, input logic [31:0] exp_data,
                         input bit early, input bit hold);
        exp_t e;
        int   lat;
        int   n;
        lat = early ? EARLY_LAT : FULL_LAT;
        @(posedge clk); #1;
        div_start = 1'b1; div_rem = rm; div_unsign = uns;
        div_rs1_data = a; div_rs2_data = b; div_rd_addr = rd; div_instr_tag = tag;
        e.data = exp_data; e.rd = rd; e.tag = tag; e.cyc = cyc + lat;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!hold) div_start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!exu_div_busy) break;
            n++;
        end
        div_start = 1'b0;
        chk("busy_cycles", 32'(n), 32'(lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(exu_div_busy), 32'd0);
        chk("rst_valid", 32'(div_wb_valid), 32'd0);
        chk("rst_data", div_wb_data, 32'd0);
        chk("rst_rd", 32'(div_wb_rd_addr), 32'd0);
        chk("rst_tag", 32'(div_wb_tag), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //     rem  uns  a             b             rd     tag    expected      early hold
        issue(1'b0, 1'b1, 32'd100,      32'd7,        5'd3,  8'h11, 32'd14,       1'b0, 1'b0);
        issue(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        5'd4,  8'h12, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        5'd5,  8'h13, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 32'd5,        32'd0,        5'd6,  8'h14, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 32'd5,        32'd0,        5'd7,  8'h15, 32'd5,        1'b1, 1'b0);
        issue(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd8,  8'h16, 32'h80000000, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd9,  8'h17, 32'd0,        1'b1, 1'b0);
        issue(1'b0, 1'b1, 32'd3,        32'd9,        5'd10, 8'h18, 32'd0,        1'b1, 1'b0);
        issue(1'b1, 1'b1, 32'd3,        32'd9,        5'd11, 8'h19, 32'd3,        1'b1, 1'b0);
        issue(1'b0, 1'b0, 32'hFFFFFFFB, 32'd0,        5'd12, 8'h1A, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 32'hFFFFFFFB, 32'd0,        5'd13, 8'h1B, 32'hFFFFFFFB, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        5'd14, 8'h1C, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 5'd15, 8'h1D, 32'd1,        1'b0, 1'b0);
        issue(1'b0, 1'b0, 32'd7,        32'hFFFFFFFD, 5'd16, 8'h1E, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 32'h80000000, 32'd2,        5'd17, 8'h1F, 32'hC0000000, 1'b0, 1'b0);

        // Start held high across a whole op: exactly one writeback.
        issue(1'b0, 1'b1, 32'd1000,     32'd10,       5'd18, 8'h20, 32'd100,      1'b0, 1'b1);

        // Flush in the middle of CALC: no writeback, busy drops next cycle.
        @(posedge clk); #1;
        c0 = cyc;
        div_start = 1'b1; div_rem = 1'b0; div_unsign = 1'b1;
        div_rs1_data = 32'd50; div_rs2_data = 32'd5; div_rd_addr = 5'd19; div_instr_tag = 8'h21;
        @(posedge clk); #1;
        div_start = 1'b0;
        while (cyc < c0 + 10) begin @(posedge clk); #1; end
        pipe_flush = 1'b1;
        @(negedge clk);
        chk("busy_before_flush", 32'(exu_div_busy), 32'd1);
        @(posedge clk); #1;
        pipe_flush = 1'b0;
        @(negedge clk);
        chk("busy_after_flush", 32'(exu_div_busy), 32'd0);

        // Start coincident with flush is dropped.
        @(posedge clk); #1;
        div_start = 1'b1; pipe_flush = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0; pipe_flush = 1'b0;
        @(negedge clk);
        chk("start_with_flush", 32'(exu_div_busy), 32'd0);

        // Normal op after flush, then a check that outputs hold once valid drops.
        issue(1'b1, 1'b1, 32'd50,       32'd7,        5'd20, 8'h22, 32'd1,        1'b0, 1'b0);
        @(negedge clk);
        chk("hold_data", div_wb_data, 32'd1);
        chk("hold_tag", 32'(div_wb_tag), 32'h22);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
